// File: rtl/aes_decryption_iter.sv
// Iterative AES-128 inverse cipher: expands the key into an 11-entry round-key store, then one inverse round per clock.
// Latency: result valid 21 edges after the accepting edge, 11 when the key matches the last fully expanded key.
// Backpressure: IN_READY only in IDLE; the result is held with OUT_VALID until OUT_READY, no input queue.
module aes_decryption_iter #(
    parameter bit CACHE_KEY = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] ENCRYPTED_DATA,
    input  logic [127:0] CIPHER_KEY,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] DECRYPTED_DATA
);

    // Byte 0 (state s(0,0)) sits in bits [127:120]; bytes run column-major towards the LSB.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_ADDKEY, S_ROUND, S_DONE} state_t;

    state_t       state, state_nxt;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] rk [0:10];
    logic         cache_vld;
    logic         cache_hit;
    logic [127:0] round_out;

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] inv_sb(input logic [7:0] x);
        return INV_SBOX[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    // Multiply by 2 in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One key-schedule step: next round key from the previous one.
    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sb(w3[23:16]) ^ rc, sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // InvMixColumns on one column using the 0E/0B/0D/09 coefficients.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0]  a [4];
        logic [7:0]  m9 [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  me [4];
        logic [7:0]  x2, x4, x8;
        logic [31:0] o;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        for (int j = 0; j < 4; j++)
            o[31-8*j -: 8] = me[j] ^ mb[(j+1)%4] ^ md[(j+2)%4] ^ m9[(j+3)%4];
        return o;
    endfunction

    // InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic mix);
        logic [127:0] t;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(r+4*c) -: 8] = inv_sb(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
        t = t ^ k;
        if (mix)
            for (int c = 0; c < 4; c++)
                t[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
        return t;
    endfunction

    assign cache_hit = (CACHE_KEY != 1'b0) && cache_vld && (CIPHER_KEY == rk[0]);
    assign round_out = inv_round(st, rk[cnt], cnt != 4'd0);

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state)
            S_IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) state_nxt = cache_hit ? S_ADDKEY : S_KEYEXP;
            end
            S_KEYEXP: if (cnt == 4'd10) state_nxt = S_ADDKEY;
            S_ADDKEY: state_nxt = S_ROUND;
            S_ROUND:  if (cnt == 4'd0) state_nxt = S_DONE;
            S_DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: cipher state, round counter, cache flag and result register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt            <= 4'd0;
            cache_vld      <= 1'b0;
            DECRYPTED_DATA <= 128'd0;
        end else begin
            case (state)
                S_IDLE: if (IN_VALID) begin
                    st  <= ENCRYPTED_DATA;
                    cnt <= 4'd1;
                end
                S_KEYEXP: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd10) cache_vld <= 1'b1;
                end
                S_ADDKEY: begin
                    st  <= st ^ rk[10];
                    cnt <= 4'd9;
                end
                S_ROUND: begin
                    st <= round_out;
                    if (cnt == 4'd0) DECRYPTED_DATA <= round_out;
                    else             cnt <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Round-key store: rk[0] loads at accept, expansion fills rk[1..10] one per cycle.
    always_ff @(posedge CLK) begin
        if (!RST && state == S_IDLE && IN_VALID) rk[0] <= CIPHER_KEY;
        else if (state == S_KEYEXP)              rk[cnt] <= key_step(rk[cnt - 4'd1], rcon(cnt));
    end

endmodule
